kofn_qualify_detect: RTL and testbench

- Parametrised, clocked successor to the combinational "at least two of four inputs high" puzzle block.
- Samples an N_IN-bit input vector on every enabled clock edge and registers its popcount.
- Asserts a registered output once at least THRESH inputs have been high for HOLD consecutive enabled samples.
- Emits rise/fall pulses and keeps a saturating count of rising events. Used as a qualified vote/majority detector in the TC-Bench sequential levels.

---
 rtl/kofn_qualify_detect.sv | 118 +++++++++++
 tb/tb_kofn_qualify_detect.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kofn_qualify_detect.sv
// Clocked K-of-N qualified vote detector: registered popcount, HOLD-sample qualification,
// rise/fall pulses and a saturating rise counter. Optional release hysteresis via KOFN_HYSTERESIS_EN.
module kofn_qualify_detect #(
  parameter int unsigned N_IN      = 4,
  parameter int unsigned THRESH    = 2,
  parameter int unsigned HOLD      = 1,
  parameter int unsigned EVT_W     = 8,
  parameter int unsigned CNT_W     = 3
`ifdef KOFN_HYSTERESIS_EN
  ,
  parameter int unsigned THRESH_LO = 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_evt,
  input  logic [N_IN-1:0]  in_vec,
  output logic [CNT_W-1:0] count,
  output logic             out,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] evt_cnt
);

  // PC_W can hold N_IN+1 so that THRESH = N_IN+1 compares without overflow.
  localparam int unsigned PC_W  = $clog2(N_IN + 2);
  localparam int unsigned RUN_W = $clog2(HOLD + 1);

  logic [PC_W-1:0]  w_pc;
  logic             w_q;
  logic [RUN_W:0]   w_run_inc;
  logic             w_hold_met;
  logic [RUN_W-1:0] w_run_next;
  logic             w_out_next;
  logic             w_rise_set;
  logic             w_fall_set;

  logic [CNT_W-1:0] r_count;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;
  logic [EVT_W-1:0] r_evt;
  logic [RUN_W-1:0] r_run;

  always_comb begin
    w_pc = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      w_pc = w_pc + PC_W'(in_vec[i]);
    end
  end

  assign w_q        = (32'(w_pc) >= 32'(THRESH));
  assign w_run_inc  = {1'b0, r_run} + (RUN_W + 1)'(1);
  assign w_hold_met = (w_run_inc >= (RUN_W + 1)'(HOLD));

`ifdef KOFN_HYSTERESIS_EN
  logic w_q_lo;
  assign w_q_lo = (32'(w_pc) >= 32'(THRESH_LO));

  // While asserted, only the low threshold matters and run is pinned at HOLD.
  always_comb begin
    w_out_next = 1'b0;
    w_run_next = '0;
    if (r_out) begin
      w_out_next = w_q_lo;
      w_run_next = w_q_lo ? RUN_W'(HOLD) : '0;
    end else if (w_q) begin
      w_out_next = w_hold_met;
      w_run_next = w_hold_met ? RUN_W'(HOLD) : w_run_inc[RUN_W-1:0];
    end
  end
`else
  always_comb begin
    w_out_next = 1'b0;
    w_run_next = '0;
    if (w_q) begin
      w_out_next = w_hold_met;
      w_run_next = w_hold_met ? RUN_W'(HOLD) : w_run_inc[RUN_W-1:0];
    end
  end
`endif

  assign w_rise_set = en && !r_out && w_out_next;
  assign w_fall_set = en && r_out && !w_out_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_evt   <= '0;
      r_run   <= '0;
    end else begin
      r_rise <= w_rise_set;
      r_fall <= w_fall_set;
      if (en) begin
        r_count <= CNT_W'(w_pc);
        r_run   <= w_run_next;
        r_out   <= w_out_next;
      end
      // Clear beats a coincident rise; otherwise count rises without wrapping.
      if (clr_evt) begin
        r_evt <= '0;
      end else if (w_rise_set && (r_evt != '1)) begin
        r_evt <= r_evt + EVT_W'(1);
      end
    end
  end

  assign count   = r_count;
  assign out     = r_out;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign evt_cnt = r_evt;

endmodule

// File: tb/tb_kofn_qualify_detect.sv
// Directed scoreboard bench for kofn_qualify_detect: several parameterisations share one stimulus
// stream; expected values are queued when driven and checked 1 ns after the clock edge.
module tb_kofn_qualify_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr_evt = 1'b0;
  logic [3:0] in_vec = '0;

  always #5 clk = ~clk;

  // d: defaults, h: HOLD=3, s: EVT_W=2, z: THRESH=0, f: THRESH=5, y: hysteresis
  logic [2:0] d_count, h_count, s_count, z_count, f_count;
  logic       d_out, h_out, s_out, z_out, f_out;
  logic       d_rise, h_rise, s_rise, z_rise, f_rise;
  logic       d_fall, h_fall, s_fall, z_fall, f_fall;
  logic [7:0] d_evt, h_evt, z_evt, f_evt;
  logic [1:0] s_evt;

  kofn_qualify_detect #(
    .N_IN(4), .THRESH(2), .HOLD(1), .EVT_W(8), .CNT_W(3)
`ifdef KOFN_HYSTERESIS_EN
    , .THRESH_LO(2)
`endif
  ) u_d (.clk(clk), .rst(rst), .en(en), .clr_evt(clr_evt), .in_vec(in_vec),
         .count(d_count), .out(d_out), .rise(d_rise), .fall(d_fall), .evt_cnt(d_evt));

  kofn_qualify_detect #(
    .N_IN(4), .THRESH(2), .HOLD(3), .EVT_W(8), .CNT_W(3)
`ifdef KOFN_HYSTERESIS_EN
    , .THRESH_LO(2)
`endif
  ) u_h (.clk(clk), .rst(rst), .en(en), .clr_evt(clr_evt), .in_vec(in_vec),
         .count(h_count), .out(h_out), .rise(h_rise), .fall(h_fall), .evt_cnt(h_evt));

  kofn_qualify_detect #(
    .N_IN(4), .THRESH(2), .HOLD(1), .EVT_W(2), .CNT_W(3)
`ifdef KOFN_HYSTERESIS_EN
    , .THRESH_LO(2)
`endif
  ) u_s (.clk(clk), .rst(rst), .en(en), .clr_evt(clr_evt), .in_vec(in_vec),
         .count(s_count), .out(s_out), .rise(s_rise), .fall(s_fall), .evt_cnt(s_evt));

  kofn_qualify_detect #(
    .N_IN(4), .THRESH(0), .HOLD(1), .EVT_W(8), .CNT_W(3)
`ifdef KOFN_HYSTERESIS_EN
    , .THRESH_LO(0)
`endif
  ) u_z (.clk(clk), .rst(rst), .en(en), .clr_evt(clr_evt), .in_vec(in_vec),
         .count(z_count), .out(z_out), .rise(z_rise), .fall(z_fall), .evt_cnt(z_evt));

  kofn_qualify_detect #(
    .N_IN(4), .THRESH(5), .HOLD(1), .EVT_W(8), .CNT_W(3)
`ifdef KOFN_HYSTERESIS_EN
    , .THRESH_LO(5)
`endif
  ) u_f (.clk(clk), .rst(rst), .en(en), .clr_evt(clr_evt), .in_vec(in_vec),
         .count(f_count), .out(f_out), .rise(f_rise), .fall(f_fall), .evt_cnt(f_evt));

`ifdef KOFN_HYSTERESIS_EN
  logic [2:0] y_count;
  logic       y_out, y_rise, y_fall;
  logic [7:0] y_evt;
  kofn_qualify_detect #(
    .N_IN(4), .THRESH(3), .HOLD(1), .EVT_W(8), .CNT_W(3), .THRESH_LO(1)
  ) u_y (.clk(clk), .rst(rst), .en(en), .clr_evt(clr_evt), .in_vec(in_vec),
         .count(y_count), .out(y_out), .rise(y_rise), .fall(y_fall), .evt_cnt(y_evt));
`endif

  typedef enum int {
    P_D_COUNT, P_D_OUT, P_D_RISE, P_D_FALL, P_D_EVT,
    P_H_COUNT, P_H_OUT, P_H_RISE, P_H_FALL,
    P_S_EVT, P_Z_OUT, P_F_OUT, P_Y_OUT, P_Y_FALL
  } probe_e;

  typedef struct {
    string       tag;
    probe_e      sel;
    logic [31:0] exp;
  } chk_t;

  chk_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] probe(probe_e sel);
    case (sel)
      P_D_COUNT: return 32'(d_count);
      P_D_OUT:   return 32'(d_out);
      P_D_RISE:  return 32'(d_rise);
      P_D_FALL:  return 32'(d_fall);
      P_D_EVT:   return 32'(d_evt);
      P_H_COUNT: return 32'(h_count);
      P_H_OUT:   return 32'(h_out);
      P_H_RISE:  return 32'(h_rise);
      P_H_FALL:  return 32'(h_fall);
      P_S_EVT:   return 32'(s_evt);
      P_Z_OUT:   return 32'(z_out);
      P_F_OUT:   return 32'(f_out);
`ifdef KOFN_HYSTERESIS_EN
      P_Y_OUT:   return 32'(y_out);
      P_Y_FALL:  return 32'(y_fall);
`endif
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input probe_e sel, input int unsigned exp);
    chk_t c;
    c.tag = tag;
    c.sel = sel;
    c.exp = 32'(exp);
    exp_q.push_back(c);
  endtask

  task automatic step(input logic [3:0] v, input logic e, input logic c, input logic r);
    chk_t        item;
    logic [31:0] got;
    in_vec  = v;
    en      = e;
    clr_evt = c;
    rst     = r;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      got  = probe(item.sel);
      checks++;
      assert (got === item.exp) else begin
        errors++;
        $error("FAIL %s got=%0d exp=%0d", item.tag, got, item.exp);
      end
    end
  endtask

  initial begin
    int unsigned pc;
    int unsigned rises;
    logic        prev;
    logic        now;
    logic [3:0]  v;

    // Reset state
    push("rst_count", P_D_COUNT, 0);
    push("rst_out", P_D_OUT, 0);
    push("rst_rise", P_D_RISE, 0);
    push("rst_fall", P_D_FALL, 0);
    push("rst_evt", P_D_EVT, 0);
    push("rst_z_out", P_Z_OUT, 0);
    step(4'b0000, 1'b1, 1'b0, 1'b1);

    // Full sweep of the 16 input codes on the default configuration
    prev = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      v   = 4'(k);
      pc  = $countones(v);
      now = (pc >= 2);
      push("sweep_count", P_D_COUNT, pc);
      push("sweep_out", P_D_OUT, 32'(now));
      push("sweep_rise", P_D_RISE, 32'(!prev && now));
      push("sweep_fall", P_D_FALL, 32'(prev && !now));
      step(v, 1'b1, 1'b0, 1'b0);
      prev = now;
    end

    // HOLD=3 assertion latency and immediate release
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    push("hold_e1_out", P_H_OUT, 0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    push("hold_e2_out", P_H_OUT, 0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    push("hold_e3_out", P_H_OUT, 1);
    push("hold_e3_rise", P_H_RISE, 1);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    push("hold_e4_out", P_H_OUT, 1);
    push("hold_e4_rise", P_H_RISE, 0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    push("hold_rel_out", P_H_OUT, 0);
    push("hold_rel_fall", P_H_FALL, 1);
    step(4'b0001, 1'b1, 1'b0, 1'b0);
    push("hold_rel_fall_end", P_H_FALL, 0);
    step(4'b0001, 1'b1, 1'b0, 1'b0);

    // Event counter: 6 rises, saturation at EVT_W=2, then clear coincident with a rise
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    rises = 0;
    for (int unsigned k = 1; k <= 12; k++) begin
      if (k % 2 == 1) rises++;
      push("evt_rise", P_D_RISE, 32'(k % 2 == 1));
      push("evt_cnt", P_D_EVT, rises);
      push("evt_sat", P_S_EVT, (rises > 3) ? 3 : rises);
      step((k % 2 == 1) ? 4'b0011 : 4'b0000, 1'b1, 1'b0, 1'b0);
    end
    push("evt_clr_rise", P_D_RISE, 1);
    push("evt_clr_cnt", P_D_EVT, 0);
    push("evt_clr_sat", P_S_EVT, 0);
    step(4'b0011, 1'b1, 1'b1, 1'b0);
    push("evt_after_clr", P_D_EVT, 0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);

    // Enable gap does not break a qualifying run; clr_evt still acts while en=0
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    push("gap_pre1_out", P_H_OUT, 0);
    push("gap_pre1_devt", P_D_EVT, 1);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    push("gap_pre2_out", P_H_OUT, 0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 5; k++) begin
      push("gap_out", P_H_OUT, 0);
      push("gap_count", P_H_COUNT, 2);
      push("gap_rise", P_H_RISE, 0);
      push("gap_devt", P_D_EVT, (k >= 2) ? 0 : 1);
      step(4'b1111, 1'b0, (k == 2) ? 1'b1 : 1'b0, 1'b0);
    end
    push("gap_post_out", P_H_OUT, 1);
    push("gap_post_rise", P_H_RISE, 1);
    step(4'b0011, 1'b1, 1'b0, 1'b0);

    // Reset mid-run discards the partial run
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    push("mrst_out", P_H_OUT, 0);
    push("mrst_count", P_H_COUNT, 0);
    step(4'b0011, 1'b1, 1'b0, 1'b1);
    push("mrst_e1_out", P_H_OUT, 0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    push("mrst_e2_out", P_H_OUT, 0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    push("mrst_e3_out", P_H_OUT, 1);
    step(4'b0011, 1'b1, 1'b0, 1'b0);

    // Threshold boundaries
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    push("th0_out", P_Z_OUT, 1);
    push("th5_out", P_F_OUT, 0);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 3; k++) begin
      push("th5_full_out", P_F_OUT, 0);
      push("th0_full_out", P_Z_OUT, 1);
      step(4'b1111, 1'b1, 1'b0, 1'b0);
    end

`ifdef KOFN_HYSTERESIS_EN
    // Hysteresis: assert at 3, hold while pc >= 1
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    push("hys_e1_out", P_Y_OUT, 1);
    push("hys_e1_fall", P_Y_FALL, 0);
    step(4'b0111, 1'b1, 1'b0, 1'b0);
    push("hys_e2_out", P_Y_OUT, 1);
    push("hys_e2_fall", P_Y_FALL, 0);
    step(4'b0011, 1'b1, 1'b0, 1'b0);
    push("hys_e3_out", P_Y_OUT, 1);
    push("hys_e3_fall", P_Y_FALL, 0);
    step(4'b0001, 1'b1, 1'b0, 1'b0);
    push("hys_e4_out", P_Y_OUT, 0);
    push("hys_e4_fall", P_Y_FALL, 1);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
